// File: rtl/input_conditioner_if.sv
// input_conditioner_if: groups the pushbutton, switch and conditioned-output signals of
// input_conditioner so the front end and its consumer share one bundle.
//   nenter       raw active-low pushbutton (asynchronous, bouncy)
//   switches     raw slide switches (asynchronous)
//   enter        one-cycle pulse per accepted press
//   inputdata    switch value captured with the last enter pulse
//   press_count  accepted presses modulo 16
// Modports: master drives the raw inputs and observes the outputs; slave is the conditioner.
interface input_conditioner_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              nenter;
  logic [DATA_W-1:0] switches;
  logic              enter;
  logic [DATA_W-1:0] inputdata;
  logic [3:0]        press_count;

  modport master (
    output nenter,
    output switches,
    input  enter,
    input  inputdata,
    input  press_count
  );

  modport slave (
    input  nenter,
    input  switches,
    output enter,
    output inputdata,
    output press_count
  );

endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes the active-low ENTER pushbutton and the switch bus,
// debounces the button and emits exactly one single-cycle enter pulse per physical press,
// latching the synchronized switch value alongside that pulse.
// Ports:
//   clk     system clock, all state on the rising edge
//   nreset  synchronous active-low reset
//   bus     input_conditioner_if.slave:
//             nenter, switches            raw asynchronous inputs
//             enter, inputdata, press_count registered outputs
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or release (must be >= 2)
//   DATA_W           switch bus / latched data width
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DATA_W          = 8
) (
  input logic                clk,
  input logic                nreset,
  input_conditioner_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDbPress,
    StPressed,
    StDbRelease
  } state_e;

  // Two-flop synchronizers; button stages reset to the released level.
  logic              nenter_s1_q;
  logic              nenter_s2_q;
  logic [DATA_W-1:0] sw_s1_q;
  logic [DATA_W-1:0] sw_s2_q;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              enter_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        press_cnt_q;

  logic              btn;

  assign btn = ~nenter_s2_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      nenter_s1_q <= 1'b1;
      nenter_s2_q <= 1'b1;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
    end else begin
      nenter_s1_q <= bus.nenter;
      nenter_s2_q <= nenter_s1_q;
      sw_s1_q     <= bus.switches;
      sw_s2_q     <= sw_s1_q;
    end
  end

  // Debounce FSM. Reset lands in StDbRelease so a button held through reset is treated as
  // already pressed and must be seen released for the full debounce window first.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= StDbRelease;
      cnt_q       <= '0;
      enter_q     <= 1'b0;
      data_q      <= '0;
      press_cnt_q <= '0;
    end else begin
      enter_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (btn) begin
            state_q <= StDbPress;
            cnt_q   <= '0;
          end
        end
        StDbPress: begin
          if (!btn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= StPressed;
            cnt_q       <= '0;
            enter_q     <= 1'b1;
            data_q      <= sw_s2_q;
            press_cnt_q <= press_cnt_q + 4'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPressed: begin
          if (!btn) begin
            state_q <= StDbRelease;
            cnt_q   <= '0;
          end
        end
        StDbRelease: begin
          // A bounce back to pressed returns to StPressed without a new pulse.
          if (btn) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StDbRelease;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.enter       = enter_q;
  assign bus.inputdata   = data_q;
  assign bus.press_count = press_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int unsigned N = 4;

  logic clk;
  logic nreset;

  input_conditioner_if #(.DATA_W(8)) bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .DATA_W         (8)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a 2-sample delay line on the raw inputs, then a run-length debouncer.
  // The debounced level flips to the delayed button level once that level has disagreed with
  // it for N+1 consecutive samples; a flip to pressed emits a pulse and latches the delayed
  // switches. Reset counts as one sample already seen towards "released" on a pressed level.
  int         cyc = 0;
  logic       m_p1n, m_p2n;
  logic [7:0] m_p1s, m_p2s;
  logic       m_lvl;
  int         m_run;
  logic       m_enter;
  logic [7:0] m_data;
  int         m_count;

  task automatic model_step();
    logic b;
    cyc++;
    if (!nreset) begin
      m_p1n = 1'b1; m_p2n = 1'b1; m_p1s = 8'h00; m_p2s = 8'h00;
      m_lvl = 1'b1; m_run = 1;
      m_enter = 1'b0; m_data = 8'h00; m_count = 0;
    end else begin
      b = ~m_p2n;
      m_enter = 1'b0;
      if (b != m_lvl) begin
        m_run++;
        if (m_run == N + 1) begin
          m_lvl = b;
          m_run = 0;
          if (b) begin
            m_enter = 1'b1;
            m_data  = m_p2s;
            m_count = (m_count + 1) % 16;
          end
        end
      end else begin
        m_run = 0;
      end
      m_p2n = m_p1n; m_p2s = m_p1s;
      m_p1n = bus.nenter; m_p1s = bus.switches;
    end
  endtask

  int   pulses          = 0;
  int   fall_edge       = 0;
  int   last_pulse_edge = 0;
  logic prev_enter      = 1'b0;

  // Called at a falling edge: drive inputs, let one rising edge pass, compare at the next fall.
  task automatic cycle(input logic nen, input logic [7:0] sw, input logic rst);
    if (bus.nenter && !nen) fall_edge = cyc + 1;
    bus.nenter   = nen;
    bus.switches = sw;
    nreset       = rst;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("enter", {31'd0, bus.enter}, {31'd0, m_enter});
    check_eq("inputdata", {24'd0, bus.inputdata}, {24'd0, m_data});
    check_eq("press_count", {28'd0, bus.press_count}, m_count);
    check_eq("no_back_to_back", {31'd0, prev_enter & bus.enter}, 32'd0);
    prev_enter = bus.enter;
    if (bus.enter) begin
      pulses++;
      last_pulse_edge = cyc;
    end
  endtask

  task automatic hold(input logic nen, input logic [7:0] sw, input int n);
    for (int i = 0; i < n; i++) cycle(nen, sw, 1'b1);
  endtask

  initial begin
    logic [7:0] sw;
    int         base;
    bus.nenter   = 1'b1;
    bus.switches = 8'h00;
    nreset       = 1'b0;
    @(negedge clk);

    // 1: reset with button released
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
    check_eq("rst_enter", {31'd0, bus.enter}, 32'd0);
    check_eq("rst_inputdata", {24'd0, bus.inputdata}, 32'h00);
    check_eq("rst_press_count", {28'd0, bus.press_count}, 32'd0);
    // Press lands just as the FSM reaches idle (first btn sample on edge N+1 after release).
    hold(1'b1, 8'h00, 2);

    // 2: clean press of 12 cycles
    pulses = 0;
    hold(1'b0, 8'hA2, 12);
    hold(1'b1, 8'hA2, 10);
    check_eq("t2_pulses", pulses, 32'd1);
    check_eq("t2_latency", last_pulse_edge - fall_edge, 32'd6);
    check_eq("t2_inputdata", {24'd0, bus.inputdata}, 32'hA2);
    check_eq("t2_press_count", {28'd0, bus.press_count}, 32'd1);

    // 3: short bounces only
    pulses = 0;
    hold(1'b0, 8'h99, 2);
    hold(1'b1, 8'h99, 3);
    hold(1'b0, 8'h99, 2);
    hold(1'b1, 8'h99, 10);
    check_eq("t3_pulses", pulses, 32'd0);
    check_eq("t3_inputdata", {24'd0, bus.inputdata}, 32'hA2);
    check_eq("t3_press_count", {28'd0, bus.press_count}, 32'd1);

    // 4: long hold, switches moved mid-hold
    pulses = 0;
    hold(1'b0, 8'h33, 20);
    hold(1'b0, 8'h5C, 20);
    hold(1'b1, 8'h5C, 10);
    check_eq("t4_pulses", pulses, 32'd1);
    check_eq("t4_inputdata", {24'd0, bus.inputdata}, 32'h33);
    check_eq("t4_press_count", {28'd0, bus.press_count}, 32'd2);

    // 5: release bounce, then sixteen clean presses wrapping the counter
    pulses = 0;
    hold(1'b0, 8'h3C, 10);
    hold(1'b1, 8'h3C, 2);
    hold(1'b0, 8'h3C, 1);
    hold(1'b1, 8'h3C, 10);
    check_eq("t5_bounce_pulses", pulses, 32'd1);
    check_eq("t5_press_count", {28'd0, bus.press_count}, 32'd3);
    base = 3;
    for (int i = 0; i < 16; i++) begin
      sw = 8'($urandom);
      hold(1'b0, sw, 8);
      hold(1'b1, sw, 8);
      check_eq("t5_wrap_count", {28'd0, bus.press_count}, (base + i + 1) % 16);
      check_eq("t5_wrap_data", {24'd0, bus.inputdata}, {24'd0, sw});
    end

    // 6: reset while debouncing a press, button held through and after reset
    pulses = 0;
    hold(1'b0, 8'h11, 3);
    cycle(1'b0, 8'h11, 1'b0);
    cycle(1'b0, 8'h11, 1'b0);
    hold(1'b0, 8'h11, 20);
    check_eq("t6_held_pulses", pulses, 32'd0);
    check_eq("t6_inputdata", {24'd0, bus.inputdata}, 32'h00);
    check_eq("t6_press_count", {28'd0, bus.press_count}, 32'd0);
    hold(1'b1, 8'h11, 6);
    hold(1'b0, 8'h77, 10);
    hold(1'b1, 8'h77, 8);
    check_eq("t6_new_pulses", pulses, 32'd1);
    check_eq("t6_new_inputdata", {24'd0, bus.inputdata}, 32'h77);

    // Random bouncy button, moving switches and occasional resets against the model.
    for (int seg = 0; seg < 150; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        cycle(lvl, 8'($urandom), ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
